// File: rtl/cnu_ctrl_pkg.sv
// Shared types and limits for the CNU write-update controller.
// Pure declarations: no logic, no latency, no flow control.
package cnu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2
  } ch_state_e;

  typedef enum logic {
    MODE_INIT = 1'b0,
    MODE_PIPE = 1'b1
  } load_mode_e;

  localparam int MAX_CH         = 32;
  localparam int MAX_SYNC_DEPTH = 4;
  localparam int MIN_WR_PULSE   = 1;
  localparam int MAX_WR_PULSE   = 15;
  localparam int PULSE_CNT_W    = 4;

endpackage

// File: rtl/cnu_wr_update_ch.sv
// One CNU channel: request sync/edge detect, IDLE/ARMED/WRITE FSM, write window, overrun flag.
// Write window starts SYNC_DEPTH+1 edges after the request level; new requests while busy are dropped and flagged.
module cnu_wr_update_ch
  import cnu_ctrl_pkg::*;
#(
  parameter int SYNC_DEPTH = 2,
  parameter int WR_PULSE   = 2
) (
  input  logic read_clk,
  input  logic rstn,
  input  logic ch_en_i,
  input  logic iter_update_i,
  input  logic cnu_rd_finish_i,
  input  logic cnu_init_load_en_i,
  input  logic overrun_clr_i,
  output logic cnu_wr_o,
  output logic init_load_o,
  output logic pipe_load_o,
  output logic busy_o,
  output logic overrun_o,
  output logic done_o
);

  localparam logic [PULSE_CNT_W-1:0] CNT_LOAD = PULSE_CNT_W'(WR_PULSE - 1);

  logic req;
  logic req_d_q;
  logic req_edge;

  generate
    if (SYNC_DEPTH == 0) begin : g_bypass
      assign req = iter_update_i;
    end else begin : g_sync
      logic [SYNC_DEPTH-1:0] sync_q;
      always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= iter_update_i;
          for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign req = sync_q[SYNC_DEPTH-1];
    end
  endgenerate

  assign req_edge = req & ~req_d_q;

  ch_state_e              state_q, state_d;
  load_mode_e             mode_q, mode_d;
  logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic                   ovr_q, ovr_d;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      req_d_q <= 1'b0;
      state_q <= ST_IDLE;
      mode_q  <= MODE_INIT;
      cnt_q   <= '0;
      first_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      req_d_q <= req;
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_edge && ch_en_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // Disable beats any load request waiting in the same cycle.
        if (!ch_en_i) begin
          state_d = ST_IDLE;
        end else if (cnu_init_load_en_i || cnu_rd_finish_i) begin
          state_d = ST_WRITE;
          mode_d  = cnu_init_load_en_i ? MODE_INIT : MODE_PIPE;
          cnt_d   = CNT_LOAD;
          first_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - PULSE_CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set wins over clear when both land in the same cycle.
  always_comb begin
    ovr_d = ovr_q;
    if (req_edge && (state_q != ST_IDLE)) ovr_d = 1'b1;
    else if (overrun_clr_i)               ovr_d = 1'b0;
  end

  assign cnu_wr_o    = (state_q == ST_WRITE);
  assign init_load_o = first_q && (mode_q == MODE_INIT);
  assign pipe_load_o = first_q && (mode_q == MODE_PIPE);
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = ovr_q;
  assign done_o      = (state_q == ST_WRITE) && (cnt_q == '0);

endmodule

// File: rtl/cnu_wr_update_ctrl_mc.sv
// Multi-channel CNU write-update controller: per-channel handshakes plus done bitmap and update counter.
// all_done_o/upd_cnt_o follow a completion by 1-2 edges; no backpressure, requests while busy are flagged.
module cnu_wr_update_ctrl_mc
  import cnu_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int WR_PULSE   = 2,
  parameter int CNT_W      = 8
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic [NUM_CH-1:0] iter_update_i,
  input  logic [NUM_CH-1:0] cnu_rd_finish_i,
  input  logic [NUM_CH-1:0] cnu_init_load_en_i,
  input  logic              overrun_clr_i,
  output logic [NUM_CH-1:0] cnu_wr_o,
  output logic [NUM_CH-1:0] init_load_o,
  output logic [NUM_CH-1:0] pipe_load_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] overrun_o,
  output logic              all_done_o,
  output logic [CNT_W-1:0]  upd_cnt_o
);

  generate
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("cnu_wr_update_ctrl_mc: NUM_CH out of range");
    end
    if (SYNC_DEPTH < 0 || SYNC_DEPTH > MAX_SYNC_DEPTH) begin : g_bad_sync
      $error("cnu_wr_update_ctrl_mc: SYNC_DEPTH out of range");
    end
    if (WR_PULSE < MIN_WR_PULSE || WR_PULSE > MAX_WR_PULSE) begin : g_bad_pulse
      $error("cnu_wr_update_ctrl_mc: WR_PULSE out of range");
    end
  endgenerate

  logic [NUM_CH-1:0] cmpl;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      cnu_wr_update_ch #(
        .SYNC_DEPTH (SYNC_DEPTH),
        .WR_PULSE   (WR_PULSE)
      ) u_ch (
        .read_clk           (read_clk),
        .rstn               (rstn),
        .ch_en_i            (ch_en_i[g]),
        .iter_update_i      (iter_update_i[g]),
        .cnu_rd_finish_i    (cnu_rd_finish_i[g]),
        .cnu_init_load_en_i (cnu_init_load_en_i[g]),
        .overrun_clr_i      (overrun_clr_i),
        .cnu_wr_o           (cnu_wr_o[g]),
        .init_load_o        (init_load_o[g]),
        .pipe_load_o        (pipe_load_o[g]),
        .busy_o             (busy_o[g]),
        .overrun_o          (overrun_o[g]),
        .done_o             (cmpl[g])
      );
    end
  endgenerate

  logic [NUM_CH-1:0] done_q, done_d;
  logic              all_done_q, all_set;
  logic [CNT_W-1:0]  upd_q, upd_d;

  // Completions landing in the clearing cycle seed the next round's bitmap.
  always_comb begin
    all_set = (&(done_q | ~ch_en_i)) && (|ch_en_i);
    done_d  = all_set ? cmpl : (done_q | cmpl);
    upd_d   = upd_q;
    for (int i = 0; i < NUM_CH; i++) upd_d = upd_d + CNT_W'(cmpl[i]);
  end

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      done_q     <= '0;
      all_done_q <= 1'b0;
      upd_q      <= '0;
    end else begin
      done_q     <= done_d;
      all_done_q <= all_set;
      upd_q      <= upd_d;
    end
  end

  assign all_done_o = all_done_q;
  assign upd_cnt_o  = upd_q;

endmodule

// File: tb/tb_cnu_wr_update_ctrl_mc.sv
// Bench for cnu_wr_update_ctrl_mc: directed scenarios plus random traffic against a cycle-level reference model.
// A second instance with a 2-bit counter shares all inputs to exercise counter wrap.
module tb_cnu_wr_update_ctrl_mc;

  localparam int NUM_CH = 4;
  localparam int SD     = 2;
  localparam int WRP    = 2;
  localparam int CW     = 8;

  logic              read_clk = 1'b0;
  logic              rstn     = 1'b0;
  logic [NUM_CH-1:0] ch_en_i = '0, iter_update_i = '0, cnu_rd_finish_i = '0, cnu_init_load_en_i = '0;
  logic              overrun_clr_i = 1'b0;

  logic [NUM_CH-1:0] a_wr, a_init, a_pipe, a_busy, a_ovr;
  logic              a_alld;
  logic [CW-1:0]     a_upd;
  logic [NUM_CH-1:0] b_wr, b_init, b_pipe, b_busy, b_ovr;
  logic              b_alld;
  logic [1:0]        b_upd;

  always #5 read_clk = ~read_clk;

  cnu_wr_update_ctrl_mc #(.NUM_CH(NUM_CH), .SYNC_DEPTH(SD), .WR_PULSE(WRP), .CNT_W(CW)) dut (
    .read_clk(read_clk), .rstn(rstn), .ch_en_i(ch_en_i), .iter_update_i(iter_update_i),
    .cnu_rd_finish_i(cnu_rd_finish_i), .cnu_init_load_en_i(cnu_init_load_en_i),
    .overrun_clr_i(overrun_clr_i), .cnu_wr_o(a_wr), .init_load_o(a_init), .pipe_load_o(a_pipe),
    .busy_o(a_busy), .overrun_o(a_ovr), .all_done_o(a_alld), .upd_cnt_o(a_upd));

  cnu_wr_update_ctrl_mc #(.NUM_CH(NUM_CH), .SYNC_DEPTH(SD), .WR_PULSE(WRP), .CNT_W(2)) dut_w2 (
    .read_clk(read_clk), .rstn(rstn), .ch_en_i(ch_en_i), .iter_update_i(iter_update_i),
    .cnu_rd_finish_i(cnu_rd_finish_i), .cnu_init_load_en_i(cnu_init_load_en_i),
    .overrun_clr_i(overrun_clr_i), .cnu_wr_o(b_wr), .init_load_o(b_init), .pipe_load_o(b_pipe),
    .busy_o(b_busy), .overrun_o(b_ovr), .all_done_o(b_alld), .upd_cnt_o(b_upd));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: remaining write cycles per channel, armed flag, request sample history.
  int                m_wr[NUM_CH];
  logic [NUM_CH-1:0] m_arm, m_mode_init, m_ovr, m_done, m_cmpl;
  logic              m_alld;
  int                m_upd;
  logic [7:0]        m_hist[NUM_CH];
  logic              m_ev, m_busy;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_wr[c] = 0;
      m_hist[c] = '0;
    end
    m_arm = '0; m_mode_init = '0; m_ovr = '0; m_done = '0; m_alld = 1'b0; m_upd = 0;
  endtask

  task automatic model_step();
    if (!rstn) begin
      model_reset();
    end else begin
      m_cmpl = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_hist[c] = {m_hist[c][6:0], iter_update_i[c]};
        m_ev      = m_hist[c][SD] & ~m_hist[c][SD+1];
        m_busy    = m_arm[c] || (m_wr[c] > 0);
        if (m_ev && m_busy)     m_ovr[c] = 1'b1;
        else if (overrun_clr_i) m_ovr[c] = 1'b0;
        if (m_wr[c] > 0) begin
          if (m_wr[c] == 1) m_cmpl[c] = 1'b1;
          m_wr[c] = m_wr[c] - 1;
        end else if (m_arm[c]) begin
          if (!ch_en_i[c]) begin
            m_arm[c] = 1'b0;
          end else if (cnu_init_load_en_i[c] || cnu_rd_finish_i[c]) begin
            m_arm[c] = 1'b0;
            m_wr[c] = WRP;
            m_mode_init[c] = cnu_init_load_en_i[c];
          end
        end else if (m_ev && ch_en_i[c]) begin
          m_arm[c] = 1'b1;
        end
      end
      m_alld = (&(m_done | ~ch_en_i)) && (|ch_en_i);
      m_done = m_alld ? m_cmpl : (m_done | m_cmpl);
      m_upd  = m_upd + $countones(m_cmpl);
    end
  endtask

  logic [NUM_CH-1:0] e_wr, e_init, e_pipe, e_busy;
  always_comb begin
    e_wr = '0; e_init = '0; e_pipe = '0; e_busy = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e_wr[c]   = (m_wr[c] > 0);
      e_init[c] = (m_wr[c] == WRP) && m_mode_init[c];
      e_pipe[c] = (m_wr[c] == WRP) && !m_mode_init[c];
      e_busy[c] = m_arm[c] || (m_wr[c] > 0);
    end
  end

  logic [51:0] obs_vec, exp_vec;
  assign obs_vec = {a_wr, a_init, a_pipe, a_busy, a_ovr, a_alld, a_upd,
                    b_wr, b_init, b_pipe, b_busy, b_ovr, b_alld, b_upd};
  assign exp_vec = {e_wr, e_init, e_pipe, e_busy, m_ovr, m_alld, CW'(m_upd),
                    e_wr, e_init, e_pipe, e_busy, m_ovr, m_alld, 2'(m_upd)};

  task automatic tick();
    @(posedge read_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    #3;
    n_vec++;
    if (obs_vec !== '0) begin n_bad++; $display("FAIL reset_async: got %h want 0", obs_vec); end
    tick(); tick();
    n_vec++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL reset_hold: got %h want %h", obs_vec, exp_vec); end
    rstn = 1'b1;
    tick();
    n_vec++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL reset_release: got %h want %h", obs_vec, exp_vec); end
  endtask

  task automatic run_init_ch0(input string tag);
    ch_en_i = 4'b0001; cnu_init_load_en_i = 4'b0001; iter_update_i[0] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL %s_model e%0d: got %h want %h", tag, e, obs_vec, exp_vec); end
      n_vec++;
      if ({a_wr[0], a_init[0], a_pipe[0], a_alld} !== {(e == 3 || e == 4), (e == 3), 1'b0, (e == 6)}) begin
        n_bad++;
        $display("FAIL %s_timing e%0d: got wr/init/pipe/alld=%b%b%b%b", tag, e, a_wr[0], a_init[0], a_pipe[0], a_alld);
      end
    end
    n_vec++;
    if (a_upd !== 8'd1) begin n_bad++; $display("FAIL %s_count: got %0d want 1", tag, a_upd); end
    iter_update_i = '0; cnu_init_load_en_i = '0;
    tick();
  endtask

  task automatic test_init_load();
    run_init_ch0("init_load");
  endtask

  task automatic test_pipe_load();
    ch_en_i = 4'b0010; iter_update_i[1] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) cnu_rd_finish_i[1] = 1'b1;
      tick();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL pipe_model k%0d: got %h want %h", k, obs_vec, exp_vec); end
      n_vec++;
      if ({a_busy[1], a_wr[1], a_pipe[1], a_init[1]} !== {(k >= 2 && k <= 9), (k == 8 || k == 9), (k == 8), 1'b0}) begin
        n_bad++;
        $display("FAIL pipe_timing k%0d: got busy/wr/pipe/init=%b%b%b%b", k, a_busy[1], a_wr[1], a_pipe[1], a_init[1]);
      end
      n_vec++;
      if ((a_init & a_pipe) !== '0) begin n_bad++; $display("FAIL pipe_exclusive k%0d: got %b want 0", k, a_init & a_pipe); end
    end
    iter_update_i = '0; cnu_rd_finish_i = '0;
    tick();
  endtask

  task automatic test_both_ready();
    ch_en_i = 4'b0100; cnu_init_load_en_i[2] = 1'b1; cnu_rd_finish_i[2] = 1'b1; iter_update_i[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if ({a_init[2], a_pipe[2], a_wr[2]} !== {(k == 3), 1'b0, (k == 3 || k == 4)}) begin
        n_bad++;
        $display("FAIL both_prio k%0d: got init/pipe/wr=%b%b%b", k, a_init[2], a_pipe[2], a_wr[2]);
      end
    end
    n_vec++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL both_model: got %h want %h", obs_vec, exp_vec); end
    iter_update_i = '0; cnu_init_load_en_i = '0; cnu_rd_finish_i = '0;
    tick();
  endtask

  task automatic test_overrun();
    ch_en_i = 4'b1000; cnu_init_load_en_i[3] = 1'b1; iter_update_i[3] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 10) overrun_clr_i = 1'b1;
      tick();
      overrun_clr_i = 1'b0;
      if (k == 0) iter_update_i[3] = 1'b0;
      if (k == 1) iter_update_i[3] = 1'b1;
      n_vec++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL ovr_model k%0d: got %h want %h", k, obs_vec, exp_vec); end
      n_vec++;
      if ({a_ovr[3], a_wr[3]} !== {(k >= 4 && k <= 9), (k == 3 || k == 4)}) begin
        n_bad++;
        $display("FAIL ovr_timing k%0d: got ovr/wr=%b%b", k, a_ovr[3], a_wr[3]);
      end
    end
    iter_update_i = '0; cnu_init_load_en_i = '0;
    tick();
  endtask

  task automatic test_all_channels();
    int pulses;
    pulses = 0;
    rstn = 1'b0;
    model_reset();
    #2;
    rstn = 1'b1;
    ch_en_i = 4'b1111; iter_update_i = 4'b1111;
    for (int k = 0; k < 14; k++) begin
      if (k == 3) cnu_rd_finish_i = 4'b0001;
      if (k == 5) cnu_rd_finish_i = 4'b0011;
      if (k == 7) cnu_rd_finish_i = 4'b1111;
      tick();
      if (a_alld) pulses++;
      n_vec++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL all_model k%0d: got %h want %h", k, obs_vec, exp_vec); end
      n_vec++;
      if (a_alld !== (k == 10)) begin n_bad++; $display("FAIL all_done_pulse k%0d: got %b want %b", k, a_alld, (k == 10)); end
    end
    n_vec++;
    if (pulses != 1) begin n_bad++; $display("FAIL all_done_count: got %0d want 1", pulses); end
    n_vec++;
    if ({a_upd, b_upd} !== {8'd4, 2'd0}) begin n_bad++; $display("FAIL all_upd: got %0d/%0d want 4/0", a_upd, b_upd); end
    iter_update_i = '0; cnu_rd_finish_i = '0;
    tick();
  endtask

  task automatic test_wrap();
    ch_en_i = 4'b0001; cnu_init_load_en_i = 4'b0001; iter_update_i[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL wrap_model k%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    n_vec++;
    if ({a_upd, b_upd} !== {8'd5, 2'd1}) begin n_bad++; $display("FAIL wrap_count: got %0d/%0d want 5/1", a_upd, b_upd); end
    iter_update_i = '0; cnu_init_load_en_i = '0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    ch_en_i = 4'b0001; cnu_init_load_en_i = 4'b0001; iter_update_i[0] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_vec++;
    if ({a_wr[0], a_init[0]} !== 2'b11) begin n_bad++; $display("FAIL midrst_pre: got wr/init=%b%b want 11", a_wr[0], a_init[0]); end
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_vec !== '0) begin n_bad++; $display("FAIL midrst_drop: got %h want 0", obs_vec); end
    tick();
    rstn = 1'b1; iter_update_i = '0;
    tick();
    run_init_ch0("midrst_rerun");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (k % 32 == 0) ch_en_i = NUM_CH'($urandom_range(1, 15));
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 5) == 0) iter_update_i[c] = ~iter_update_i[c];
        cnu_rd_finish_i[c]    = ($urandom_range(0, 3) == 0);
        cnu_init_load_en_i[c] = ($urandom_range(0, 7) == 0);
      end
      overrun_clr_i = ($urandom_range(0, 15) == 0);
      tick();
      n_vec++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL random k%0d: got %h want %h", k, obs_vec, exp_vec); end
    end
    overrun_clr_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_load();
    test_pipe_load();
    test_both_ready();
    test_overrun();
    test_all_channels();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
